// File: rtl/mem_arbiter_if.sv
// Bus bundle between requesting units, the shared-RAM arbiter and the RAM port.
// The arbiter binds the slave modport; requesters and the RAM bind the master.
interface mem_arbiter_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    logic [NPORTS-1:0]    req_i;
    logic [NPORTS-1:0]    we_i;
    logic [NPORTS*AW-1:0] addr_i;
    logic [NPORTS*DW-1:0] wdata_i;
    logic [NPORTS-1:0]    gnt_o;
    logic [NPORTS-1:0]    rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 we_o;
    logic [AW-1:0]        addr_o;
    logic [DW-1:0]        data_o;
    logic [DW-1:0]        data_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, data_i,
        output gnt_o, rvalid_o, rdata_o, we_o, addr_o, data_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, data_i,
        input  gnt_o, rvalid_o, rdata_o, we_o, addr_o, data_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-port single-RAM arbiter: round-robin or fixed priority, one access per
// cycle, with read-return tagging over an RD_LATENCY-deep tracking pipe.
module mem_arbiter #(
    parameter int NPORTS     = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int PRIO_MODE  = 0
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    typedef logic [IW-1:0] id_t;

    id_t                   ptr_q, ptr_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    id_t [RD_LATENCY-1:0]  id_q, id_d;

    logic gnt_any;
    id_t  gnt_idx;

    // Scan from the lowest priority candidate upward so the best one wins last.
    always_comb begin : arbitrate
        int  cand;
        id_t idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        idx     = '0;
        if (!reset) begin
            for (int o = NPORTS - 1; o >= 0; o--) begin
                if (PRIO_MODE == 1) begin
                    cand = o;
                end else begin
                    cand = (int'(ptr_q) + o) % NPORTS;
                end
                idx = id_t'(cand);
                if (bus.req_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    always_comb begin : issue
        bus.gnt_o  = '0;
        bus.we_o   = 1'b0;
        bus.addr_o = '0;
        bus.data_o = '0;
        if (gnt_any) begin
            bus.gnt_o[gnt_idx] = 1'b1;
            bus.we_o           = bus.we_i[gnt_idx];
            bus.addr_o         = bus.addr_i[gnt_idx*AW +: AW];
            bus.data_o         = bus.wdata_i[gnt_idx*DW +: DW];
        end
    end

    always_comb begin : next_state
        ptr_d = ptr_q;
        vld_d = vld_q;
        id_d  = id_q;
        if (PRIO_MODE == 0 && gnt_any) begin
            if (int'(gnt_idx) == NPORTS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
        for (int s = RD_LATENCY - 1; s > 0; s--) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
        vld_d[0] = gnt_any & ~bus.we_o;
        id_d[0]  = gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    always_comb begin : read_return
        bus.rvalid_o = '0;
        if (vld_q[RD_LATENCY-1]) begin
            bus.rvalid_o[id_q[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign bus.rdata_o = bus.data_i;
endmodule
